// File: rtl/if_stage_sramlike_pkg.sv
// if_stage_sramlike_pkg: shared bus widths and fetch FSM states for the SRAM-like fetch stage
package if_stage_sramlike_pkg;
  localparam int BR_BUS_WD = 33;
  localparam int FS_TO_DS_BUS_WD = 64;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} fs_state_t;
endpackage

// File: rtl/if_stage_sramlike_fs_ibuf.sv
// fs_ibuf: synchronous FIFO holding fetched {inst, pc} words, flush beats push and pop
module fs_ibuf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               din,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [WIDTH-1:0]               dout
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (reset || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= inc(wr);
      end
      if (pop) rd <= inc(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  assign dout = mem[rd];
endmodule

// File: rtl/if_stage_sramlike.sv
// if_stage_sramlike: fetch stage on an SRAM-like instruction bus with a branch-flushable instruction buffer
module if_stage_sramlike
  import if_stage_sramlike_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int IBUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_req,
  output logic                       inst_wr,
  output logic [1:0]                 inst_size,
  output logic [31:0]                inst_addr,
  output logic [3:0]                 inst_wstrb,
  output logic [31:0]                inst_wdata,
  input  logic                       inst_addr_ok,
  input  logic                       inst_data_ok,
  input  logic [31:0]                inst_rdata
);
  localparam int CW = $clog2(IBUF_DEPTH+1);
  fs_state_t state;
  logic [31:0] fetch_pc, req_pc, redir_pc, br_target;
  logic cancel, redir_pending, br_taken, push, pop, room;
  logic [CW-1:0] count, nxt_cnt;
  assign {br_taken, br_target} = br_bus;
  assign inst_req = state == S_REQ && !reset;
  assign inst_addr = fetch_pc;
  assign inst_wr = 1'b0;
  assign inst_size = 2'b10;
  assign inst_wstrb = 4'b0;
  assign inst_wdata = 32'b0;
  assign fs_to_ds_valid = count != '0 && !reset;
  assign pop = fs_to_ds_valid && ds_allowin;
  assign push = state == S_WAIT && inst_data_ok && !cancel && !br_taken;
  // occupancy after this edge decides whether another request may be issued
  assign nxt_cnt = br_taken ? '0 : count + CW'(push) - CW'(pop);
  assign room = nxt_cnt < CW'(IBUF_DEPTH);
  fs_ibuf #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(br_taken),
    .din({inst_rdata, req_pc}),
    .count(count),
    .dout(fs_to_ds_bus)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      redir_pc <= '0;
      cancel <= 1'b0;
      redir_pending <= 1'b0;
    end else
      case (state)
        S_IDLE: begin
          if (br_taken) fetch_pc <= br_target;
          if (room) state <= S_REQ;
        end
        S_REQ:
          if (inst_addr_ok) begin
            state <= S_WAIT;
            req_pc <= fetch_pc;
            redir_pending <= 1'b0;
            cancel <= br_taken || redir_pending;
            fetch_pc <= br_taken ? br_target : redir_pending ? redir_pc : fetch_pc + 32'd4;
          end else if (br_taken) begin
            // address must hold until accepted, so remember the redirect for later
            redir_pending <= 1'b1;
            redir_pc <= br_target;
          end
        S_WAIT: begin
          if (br_taken) fetch_pc <= br_target;
          if (inst_data_ok) begin
            cancel <= 1'b0;
            state <= room ? S_REQ : S_IDLE;
          end else if (br_taken) cancel <= 1'b1;
        end
        default: state <= S_REQ;
      endcase
endmodule

// File: tb/tb_if_stage_sramlike.sv
// tb_if_stage_sramlike: directed checks of fetch sequencing, buffering, branch cancel and PC wrap
module tb_if_stage_sramlike;
  import if_stage_sramlike_pkg::*;
  logic clk = 0, reset = 1, ds_allowin = 0, inst_addr_ok = 0, inst_data_ok = 0;
  logic [BR_BUS_WD-1:0] br_bus = '0;
  logic [31:0] inst_rdata = '0;
  logic fs_to_ds_valid, inst_req, inst_wr;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic [1:0] inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0] inst_wstrb;
  int total = 0, bad = 0;

  if_stage_sramlike dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    reset = 1;
    ds_allowin = 0;
    inst_addr_ok = 0;
    inst_data_ok = 0;
    br_bus = '0;
    tick;
    tick;
    reset = 0;
    #1;
  endtask

  task test_reset;
    reset = 1;
    tick;
    tick;
    total++;
    if (inst_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold req=%b valid=%b want 0 0", inst_req, fs_to_ds_valid);
    end
    reset = 0;
    #1;
    total++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h1c000000) begin
      bad++;
      $display("FAIL reset_first_req req=%b addr=%h want 1 1c000000", inst_req, inst_addr);
    end
    total++;
    if (fs_to_ds_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_empty valid=%b want 0", fs_to_ds_valid);
    end
    total++;
    if ({inst_wr, inst_size, inst_wstrb, inst_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_consts wr=%b size=%b wstrb=%h wdata=%h want 0 10 0 0", inst_wr, inst_size, inst_wstrb, inst_wdata);
    end
  endtask

  task test_stream;
    logic [31:0] pc, w;
    do_reset;
    ds_allowin = 1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h1c000000 + 32'(4 * k);
      w = 32'ha0000000 + 32'(k);
      total++;
      if (inst_req !== 1'b1 || inst_addr !== pc) begin
        bad++;
        $display("FAIL stream_req k=%0d req=%b addr=%h want 1 %h", k, inst_req, inst_addr, pc);
      end
      inst_addr_ok = 1;
      tick;
      inst_addr_ok = 0;
      total++;
      if (inst_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
        bad++;
        $display("FAIL stream_wait k=%0d req=%b valid=%b want 0 0", k, inst_req, fs_to_ds_valid);
      end
      inst_data_ok = 1;
      inst_rdata = w;
      tick;
      inst_data_ok = 0;
      total++;
      if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {w, pc}) begin
        bad++;
        $display("FAIL stream_head k=%0d valid=%b bus=%h want 1 %h", k, fs_to_ds_valid, fs_to_ds_bus, {w, pc});
      end
    end
  endtask

  task test_full;
    do_reset;
    for (int k = 0; k < 2; k++) begin
      inst_addr_ok = 1;
      tick;
      inst_addr_ok = 0;
      inst_data_ok = 1;
      inst_rdata = 32'hb0000000 + 32'(k);
      tick;
      inst_data_ok = 0;
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (inst_req !== 1'b0 || fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'hb0000000, 32'h1c000000}) begin
        bad++;
        $display("FAIL full_idle k=%0d req=%b valid=%b bus=%h want 0 1 b00000001c000000", k, inst_req, fs_to_ds_valid, fs_to_ds_bus);
      end
      tick;
    end
    ds_allowin = 1;
    tick;
    ds_allowin = 0;
    total++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h1c000008) begin
      bad++;
      $display("FAIL full_resume req=%b addr=%h want 1 1c000008", inst_req, inst_addr);
    end
    total++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'hb0000001, 32'h1c000004}) begin
      bad++;
      $display("FAIL full_second valid=%b bus=%h want 1 b00000011c000004", fs_to_ds_valid, fs_to_ds_bus);
    end
  endtask

  task test_stall_branch;
    do_reset;
    ds_allowin = 1;
    for (int k = 0; k < 5; k++) begin
      br_bus = (k == 1) ? {1'b1, 32'h1c000100} : '0;
      total++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h1c000000) begin
        bad++;
        $display("FAIL stall_addr k=%0d req=%b addr=%h want 1 1c000000", k, inst_req, inst_addr);
      end
      tick;
    end
    br_bus = '0;
    inst_addr_ok = 1;
    tick;
    inst_addr_ok = 0;
    inst_data_ok = 1;
    inst_rdata = 32'hdeadbeef;
    tick;
    inst_data_ok = 0;
    total++;
    if (fs_to_ds_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000100) begin
      bad++;
      $display("FAIL stall_redirect valid=%b req=%b addr=%h want 0 1 1c000100", fs_to_ds_valid, inst_req, inst_addr);
    end
  endtask

  task test_wait_branch;
    do_reset;
    ds_allowin = 1;
    inst_addr_ok = 1;
    tick;
    inst_addr_ok = 0;
    br_bus = {1'b1, 32'h1c000100};
    tick;
    br_bus = '0;
    tick;
    total++;
    if (inst_req !== 1'b0) begin
      bad++;
      $display("FAIL wait_hold req=%b want 0", inst_req);
    end
    tick;
    inst_data_ok = 1;
    inst_rdata = 32'hbadbad00;
    tick;
    inst_data_ok = 0;
    total++;
    if (fs_to_ds_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000100) begin
      bad++;
      $display("FAIL wait_redirect valid=%b req=%b addr=%h want 0 1 1c000100", fs_to_ds_valid, inst_req, inst_addr);
    end
  endtask

  task test_branch_same_cycle;
    do_reset;
    inst_addr_ok = 1;
    tick;
    inst_addr_ok = 0;
    inst_data_ok = 1;
    inst_rdata = 32'hc0000000;
    tick;
    inst_data_ok = 0;
    inst_addr_ok = 1;
    tick;
    inst_addr_ok = 0;
    total++;
    if (fs_to_ds_valid !== 1'b1 || inst_req !== 1'b0) begin
      bad++;
      $display("FAIL same_setup valid=%b req=%b want 1 0", fs_to_ds_valid, inst_req);
    end
    ds_allowin = 1;
    inst_data_ok = 1;
    inst_rdata = 32'hc0000001;
    br_bus = {1'b1, 32'h1c000200};
    tick;
    ds_allowin = 0;
    inst_data_ok = 0;
    br_bus = '0;
    total++;
    if (fs_to_ds_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000200) begin
      bad++;
      $display("FAIL same_flush valid=%b req=%b addr=%h want 0 1 1c000200", fs_to_ds_valid, inst_req, inst_addr);
    end
    inst_addr_ok = 1;
    tick;
    inst_addr_ok = 0;
    inst_data_ok = 1;
    inst_rdata = 32'hc0000002;
    tick;
    inst_data_ok = 0;
    total++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'hc0000002, 32'h1c000200}) begin
      bad++;
      $display("FAIL same_target valid=%b bus=%h want 1 c00000021c000200", fs_to_ds_valid, fs_to_ds_bus);
    end
  endtask

  task test_wrap;
    do_reset;
    ds_allowin = 1;
    inst_addr_ok = 1;
    br_bus = {1'b1, 32'hfffffffc};
    tick;
    inst_addr_ok = 0;
    br_bus = '0;
    inst_data_ok = 1;
    inst_rdata = 32'h11111111;
    tick;
    inst_data_ok = 0;
    total++;
    if (fs_to_ds_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hfffffffc) begin
      bad++;
      $display("FAIL wrap_top valid=%b req=%b addr=%h want 0 1 fffffffc", fs_to_ds_valid, inst_req, inst_addr);
    end
    inst_addr_ok = 1;
    tick;
    inst_addr_ok = 0;
    inst_data_ok = 1;
    inst_rdata = 32'h22222222;
    tick;
    inst_data_ok = 0;
    total++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'h22222222, 32'hfffffffc}) begin
      bad++;
      $display("FAIL wrap_head valid=%b bus=%h want 1 22222222fffffffc", fs_to_ds_valid, fs_to_ds_bus);
    end
    total++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h00000000) begin
      bad++;
      $display("FAIL wrap_zero req=%b addr=%h want 1 00000000", inst_req, inst_addr);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_full;
    test_stall_branch;
    test_wait_branch;
    test_branch_same_cycle;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
